// File: rtl/bus_arbiter.sv
// bus_arbiter: four-requester bus arbiter with bounded grant hold.
// A grant is held until the owner signals done, drops its request, the
// arbiter is disabled, or MAX_HOLD grant cycles elapse. Each grant is
// followed by one RELEASE cycle with all grant outputs low.
// Optional feature: define BUS_ARBITER_ROUND_ROBIN_EN to select the winner
// round-robin (search upward from last winner + 1). Without it, the highest
// requesting index wins.
module bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       valid,
    output logic       timeout
);

    localparam int CNT_W = $clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       gnt_id_q, gnt_id_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       winner_s;
    logic             limit_s;
    logic             exit_s;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    logic [1:0]       ptr_q, ptr_d;

    // First set request found searching upward from p+1, wrapping modulo 4.
    function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        pick_rr = p;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                pick_rr = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

    // Round-robin winner relative to the last granted index.
    assign winner_s = pick_rr(req, ptr_q);
`else
    // Highest set index wins.
    function automatic logic [1:0] pick_fixed(input logic [3:0] r);
        if (r[3]) begin
            pick_fixed = 2'd3;
        end else if (r[2]) begin
            pick_fixed = 2'd2;
        end else if (r[1]) begin
            pick_fixed = 2'd1;
        end else begin
            pick_fixed = 2'd0;
        end
    endfunction

    // Fixed-priority winner.
    assign winner_s = pick_fixed(req);
`endif

    // Hold limit reached in the current grant cycle, and any grant-exit cause.
    assign limit_s = (cnt_q == HOLD_LAST);
    assign exit_s  = done || !req[gnt_id_q] || !enable || limit_s;

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable && (req != 4'b0000)) begin
                    state_d  = ST_GRANT;
                    gnt_d    = 4'b0001 << winner_s;
                    gnt_id_d = winner_s;
                    valid_d  = 1'b1;
                    cnt_d    = {CNT_W{1'b0}};
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
                    ptr_d    = winner_s;
`endif
                end else begin
                    state_d  = ST_IDLE;
                    gnt_d    = 4'b0000;
                    gnt_id_d = 2'b00;
                    valid_d  = 1'b0;
                    cnt_d    = {CNT_W{1'b0}};
                end
            end
            ST_GRANT: begin
                if (exit_s) begin
                    state_d   = ST_RELEASE;
                    gnt_d     = 4'b0000;
                    gnt_id_d  = 2'b00;
                    valid_d   = 1'b0;
                    cnt_d     = {CNT_W{1'b0}};
                    // Timeout only when the limit is the sole reason to leave.
                    timeout_d = limit_s && !done && req[gnt_id_q] && enable;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                gnt_d    = 4'b0000;
                gnt_id_d = 2'b00;
                valid_d  = 1'b0;
                cnt_d    = {CNT_W{1'b0}};
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = 4'b0000;
                gnt_id_d = 2'b00;
                valid_d  = 1'b0;
                cnt_d    = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'b00;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            ptr_q     <= 2'd3;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed bench for bus_arbiter (MAX_HOLD=4) with a
// transaction-level reference model compared on every falling edge plus
// hand-computed literal expectations. Follows BUS_ARBITER_ROUND_ROBIN_EN.
module tb_bus_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       valid;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the bus, how many grant cycles shown so far,
    // whether a release gap is in progress, and the pending timeout pulse.
    int m_owner  = -1;
    int m_cycles = 0;
    bit m_rel    = 1'b0;
    bit m_tmo    = 1'b0;
    int m_ptr    = 3;
    bit model_on = 1'b0;

    bus_arbiter #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int p);
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
`else
        for (int k = 3; k >= 0; k--) begin
            if (r[k]) return k;
        end
        return 0;
`endif
    endfunction

    // Advance the model across one rising edge using the inputs it will see.
    task automatic model_update();
        if (reset) begin
            m_owner = -1; m_cycles = 0; m_rel = 1'b0; m_tmo = 1'b0; m_ptr = 3;
        end else if (m_owner >= 0) begin
            if (done || !req[m_owner] || !enable || m_cycles == MH) begin
                m_tmo    = (m_cycles == MH) && !done && req[m_owner] && enable;
                m_owner  = -1;
                m_rel    = 1'b1;
                m_cycles = 0;
            end else begin
                m_cycles = m_cycles + 1;
                m_tmo    = 1'b0;
            end
        end else if (m_rel) begin
            m_rel = 1'b0;
            m_tmo = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (enable && req != 4'b0000) begin
                m_owner  = pick(req, m_ptr);
                m_ptr    = m_owner;
                m_cycles = 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (model_on) begin
            check("model_gnt",     {4'b0000, gnt},     (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0);
            check("model_gnt_id",  {6'b000000, gnt_id}, (m_owner >= 0) ? 8'(m_owner) : 8'd0);
            check("model_valid",   {7'b0000000, valid}, {7'b0000000, (m_owner >= 0)});
            check("model_timeout", {7'b0000000, timeout}, {7'b0000000, m_tmo});
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [3:0] g, input logic [1:0] id,
                              input logic v, input logic t);
        check({name, "_gnt"},     {4'b0000, gnt},       {4'b0000, g});
        check({name, "_gnt_id"},  {6'b000000, gnt_id},  {6'b000000, id});
        check({name, "_valid"},   {7'b0000000, valid},  {7'b0000000, v});
        check({name, "_timeout"}, {7'b0000000, timeout}, {7'b0000000, t});
    endtask

    logic [1:0] seq_exp [5];
    logic [3:0] tbl_req [6];
    logic [1:0] tbl_id  [6];

    initial begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        seq_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
        seq_exp = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
        tbl_req = '{4'b0001, 4'b0011, 4'b0101, 4'b1001, 4'b0111, 4'b1110};
        tbl_id  = '{2'd0,    2'd1,    2'd2,    2'd3,    2'd2,    2'd3};

        reset = 1'b1; enable = 1'b0; req = 4'b0000; done = 1'b0;
        step();
        step();
        model_on = 1'b1;
        expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Reset wins over active requests.
        enable = 1'b1; req = 4'b1111;
        step();
        expect_out("reset_prec", 4'b0000, 2'd0, 1'b0, 1'b0);

        // First grant after reset.
        reset = 1'b0; req = 4'b0110;
        step();
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        expect_out("first_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
        expect_out("first_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
`endif

        // done in the third grant cycle, then two zero cycles and regrant.
        do_reset();
        req = 4'b0100;
        step(); step(); step();
        done = 1'b1;
        step();
        expect_out("done_release", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = 1'b0;
        step();
        expect_out("idle_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        expect_out("regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Hold limit: exactly MH grant cycles, then a timeout pulse.
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < MH; i++) begin
            step();
            expect_out("hold", 4'b1000, 2'd3, 1'b1, 1'b0);
        end
        step();
        expect_out("timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
        step();
        expect_out("post_timeout", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        expect_out("regrant_after_tmo", 4'b1000, 2'd3, 1'b1, 1'b0);

        // Limit coinciding with done: release without timeout.
        do_reset();
        req = 4'b1000;
        for (int i = 0; i < MH; i++) step();
        done = 1'b1;
        step();
        expect_out("limit_with_done", 4'b0000, 2'd0, 1'b0, 1'b0);
        done = 1'b0;

        // All requesting, done pulsed each grant.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("seq_gnt_id", {6'b000000, gnt_id}, {6'b000000, seq_exp[k]});
            done = 1'b1;
            step();
            done = 1'b0;
            step();
        end

        // enable dropped mid-grant blocks further grants.
        do_reset();
        req = 4'b0001;
        step();
        expect_out("pre_disable", 4'b0001, 2'd0, 1'b1, 1'b0);
        enable = 1'b0;
        step();
        expect_out("en_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out("blocked", 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        enable = 1'b1;
        step();
        expect_out("reenable", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Reset in the middle of a grant.
        do_reset();
        req = 4'b1111;
        step(); step();
        reset = 1'b1;
        step();
        expect_out("reset_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step();
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
        expect_out("after_reset_mid", 4'b0001, 2'd0, 1'b1, 1'b0);
`else
        expect_out("after_reset_mid", 4'b1000, 2'd3, 1'b1, 1'b0);
`endif

        // Request withdrawn right after being sampled: grant then release.
        do_reset();
        req = 4'b0100;
        step();
        expect_out("brief_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        expect_out("req_drop", 4'b0000, 2'd0, 1'b0, 1'b0);

        // No preemption by a higher requester.
        do_reset();
        req = 4'b0010;
        step();
        req = 4'b1010;
        step();
        expect_out("no_preempt1", 4'b0010, 2'd1, 1'b1, 1'b0);
        step();
        expect_out("no_preempt2", 4'b0010, 2'd1, 1'b1, 1'b0);

        // Priority table; winners depend on mode, model covers both.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            req = tbl_req[k];
            step();
`ifndef BUS_ARBITER_ROUND_ROBIN_EN
            check("prio_gnt_id", {6'b000000, gnt_id}, {6'b000000, tbl_id[k]});
`endif
            done = 1'b1;
            step();
            done = 1'b0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 16: maximum cycles a grant is held before forced release (range 2..255).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1: arbiter enable; low forces release and blocks new grants.
REQ-005 SHALL have port req, input, 4: request lines, req[3]..req[0], one per requester.
REQ-006 SHALL have port done, input, 1: current owner finished; sampled only in GRANT.
REQ-007 SHALL have port gnt, output reg, 4: one-hot grant, all zero when no owner.
REQ-008 SHALL have port gnt_id, output reg, 2: encoded owner index, 2'b00 when no owner.
REQ-009 SHALL have port valid, output reg, 1: high exactly while gnt is non-zero.
REQ-010 SHALL have port timeout, output reg, 1: one-cycle pulse on forced release.

Function
REQ-011 SHALL implement three states: IDLE, GRANT, RELEASE.
REQ-012 IDLE: when enable=1 and req!=0, SHALL select a winner and enter GRANT next edge; gnt/gnt_id/valid registered, visible one cycle after req sampled.
REQ-013 IDLE with enable=0 or req=0: SHALL stay in IDLE, outputs zero.
REQ-014 Fixed priority (default): winner SHALL be highest set index, req[3] highest, req[0] lowest.
REQ-015 GRANT: SHALL hold gnt, gnt_id, valid constant; other requests ignored (no preemption).
REQ-016 GRANT: hold counter SHALL load 0 on entry and increment each cycle in GRANT; width ceil(log2(MAX_HOLD))+1, no wrap possible.
REQ-017 GRANT exit to RELEASE on any of: done=1; req[gnt_id]=0; enable=0; counter = MAX_HOLD-1 (at most MAX_HOLD grant cycles).
REQ-018 Exit caused solely by counter limit (done=0, req[owner]=1, enable=1) SHALL assert timeout for the single RELEASE cycle; any other exit cause, including simultaneous with limit, SHALL not.
REQ-019 RELEASE: gnt=0, gnt_id=0, valid=0 for exactly one cycle; then IDLE unconditionally.
REQ-020 Minimum back-to-back turnaround SHALL be: last GRANT cycle, RELEASE, IDLE, next GRANT (two idle cycles on gnt).
REQ-021 gnt SHALL never have more than one bit set; gnt_id SHALL always equal index of set gnt bit.
REQ-022 Request deasserting in IDLE same cycle winner chosen: grant still issued; REQ-017 releases it next cycle.

Reset
REQ-023 reset=1 at a clock edge SHALL force IDLE, gnt=0, gnt_id=0, valid=0, timeout=0, counter=0, round-robin pointer=3, from any state including mid-GRANT.
REQ-024 reset SHALL take precedence over enable, req, done.

Configuration
REQ-025 Macro BUS_ARBITER_ROUND_ROBIN_EN defined: winner SHALL be first set req searching upward from pointer+1 modulo 4; pointer SHALL update to winner index on entry to GRANT.
REQ-026 Macro undefined: fixed priority per REQ-014; pointer logic absent; all other behaviour identical.

Verification
REQ-027 Reset then req=4'b0110, enable=1 -> next cycle gnt=4'b0100, gnt_id=2, valid=1 (fixed); gnt=4'b0010, gnt_id=1 (round-robin, pointer=3).
REQ-028 Owner 2 held, done pulsed in 3rd grant cycle -> next cycle gnt=0 (RELEASE), timeout=0, then IDLE, regrant after two zero cycles.
REQ-029 MAX_HOLD=4, req=4'b1000 held, done=0 -> gnt=4'b1000 for exactly 4 cycles, then timeout=1 for one cycle with gnt=0.
REQ-030 Round-robin, req=4'b1111 held, done pulsed each grant -> gnt_id sequence 0,1,2,3,0.
REQ-031 enable dropped mid-GRANT -> RELEASE next cycle, timeout=0, no new grant while enable=0 despite req=4'b0001.
REQ-032 reset asserted during GRANT with req=4'b1111 -> next cycle all outputs 0, state IDLE; round-robin next winner index 0.
